// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader boot controller.
package loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    LEN,
    LO,
    HI,
    SUM,
    RUN
  } state_t;

  localparam logic [7:0]  BOOT_HDR      = 8'h55;
  localparam int unsigned DEF_PROG_BASE = 'h200;

endpackage

// File: rtl/rx_timeout.sv
// Inter-byte gap watchdog: counts idle cycles while enabled and pulses
// expired for one cycle when the gap reaches TIMEOUT_CYCLES.
module rx_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Combinational pulse; the counter wraps to zero on the same edge, so it lasts one cycle.
  assign expired = enable && !kick && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || kick || expired) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot controller: holds the CPU in reset, loads a framed UART program image
// into memory from PROG_BASE, verifies its checksum, then hands the port over.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH     = 10,
  parameter logic [ADDR_WIDTH-1:0]  PROG_BASE      = ADDR_WIDTH'(DEF_PROG_BASE),
  parameter int unsigned            TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
  input  logic                  cpu_mem_wr,
  input  logic [15:0]           cpu_wr_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr,
  output logic [15:0]           mem_wr_data,
  output logic                  cpu_rst,
  output logic                  loading,
  output logic                  load_done,
  output logic                  load_err
);

  state_t                state_q, state_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  loading_q, loading_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           data_q, data_d;
  logic [7:0]            idx_q, idx_d;
  logic [8:0]            n_q, n_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            lo_q, lo_d;

  logic tmo_en;
  logic tmo_expired;

  assign tmo_en = (state_q == LEN) || (state_q == LO) || (state_q == HI) || (state_q == SUM);

  rx_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (tmo_en),
    .kick   (rx_valid | boot_req),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HDR;
      cpu_rst_q <= 1'b1;
      loading_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= PROG_BASE;
      data_q    <= '0;
      idx_q     <= '0;
      n_q       <= '0;
      sum_q     <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      loading_q <= loading_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      idx_q     <= idx_d;
      n_q       <= n_d;
      sum_q     <= sum_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_rst_d = cpu_rst_q;
    loading_d = loading_q;
    done_d    = done_q;
    err_d     = err_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    idx_d     = idx_q;
    n_d       = n_q;
    sum_d     = sum_q;
    lo_d      = lo_q;

    if (boot_req) begin
      state_d   = HDR;
      cpu_rst_d = 1'b1;
      loading_d = 1'b1;
      done_d    = 1'b0;
      err_d     = 1'b0;
    end else if (tmo_expired) begin
      state_d = HDR;
      err_d   = 1'b1;
    end else if (rx_valid) begin
      unique case (state_q)
        HDR: begin
          if (rx_data == BOOT_HDR) state_d = LEN;
        end
        LEN: begin
          n_d     = (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
          sum_d   = rx_data;
          idx_d   = '0;
          state_d = LO;
        end
        LO: begin
          lo_d    = rx_data;
          sum_d   = sum_q + rx_data;
          state_d = HI;
        end
        HI: begin
          sum_d   = sum_q + rx_data;
          wr_d    = 1'b1;
          addr_d  = PROG_BASE + ADDR_WIDTH'({idx_q, 1'b0});
          data_d  = {rx_data, lo_q};
          idx_d   = idx_q + 8'd1;
          state_d = (({1'b0, idx_q} + 9'd1) == n_q) ? SUM : LO;
        end
        SUM: begin
          if (rx_data == sum_q) begin
            state_d   = RUN;
            cpu_rst_d = 1'b0;
            loading_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = HDR;
            err_d   = 1'b1;
          end
        end
        RUN: ;
        default: state_d = HDR;
      endcase
    end
  end

  // Mux keys off the registered loading flag so it flips together with cpu_rst.
  assign mem_addr    = loading_q ? addr_q : cpu_mem_addr;
  assign mem_wr      = loading_q ? wr_q   : cpu_mem_wr;
  assign mem_wr_data = loading_q ? data_q : cpu_wr_data;

  assign cpu_rst   = cpu_rst_q;
  assign loading   = loading_q;
  assign load_done = done_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader with a short byte timeout.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        boot_req;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [9:0]  cpu_mem_addr;
  logic        cpu_mem_wr;
  logic [15:0] cpu_wr_data;
  logic [9:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wr_data;
  logic        cpu_rst;
  logic        loading;
  logic        load_done;
  logic        load_err;

  int n_checks = 0;
  int n_errs   = 0;

  int          wr_cnt = 0;
  logic [9:0]  wr_addr [0:1023];
  logic [15:0] wr_data [0:1023];

  always #5 clk = ~clk;

  prog_loader #(
    .ADDR_WIDTH    (10),
    .PROG_BASE     (10'h200),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .boot_req    (boot_req),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wr  (cpu_mem_wr),
    .cpu_wr_data (cpu_wr_data),
    .mem_addr    (mem_addr),
    .mem_wr      (mem_wr),
    .mem_wr_data (mem_wr_data),
    .cpu_rst     (cpu_rst),
    .loading     (loading),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  // Log loader-side writes only; CPU traffic after handover is not part of the image.
  always @(negedge clk) begin
    if (mem_wr && loading && wr_cnt < 1024) begin
      wr_addr[wr_cnt] = mem_addr;
      wr_data[wr_cnt] = mem_wr_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_boot();
    boot_req = 1'b1;
    tick();
    boot_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base;

    rst_n        = 1'b0;
    boot_req     = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    cpu_mem_addr = 10'h123;
    cpu_mem_wr   = 1'b1;
    cpu_wr_data  = 16'hBEEF;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_loading", loading, 1);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 10'h200);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    cpu_mem_wr = 1'b0;

    // Good two-word frame preceded by a junk byte
    base = wr_cnt;
    send_byte(8'h33); send_byte(8'h55); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h78); send_byte(8'h56);
    check("pre_sum_cpu_rst", cpu_rst, 1);
    send_byte(8'h16);
    check("good_cpu_rst", cpu_rst, 0);
    check("good_loading", loading, 0);
    check("good_done", load_done, 1);
    check("good_err", load_err, 0);
    check("good_wr_cnt", wr_cnt - base, 2);
    check("good_addr0", wr_addr[base], 10'h200);
    check("good_data0", wr_data[base], 16'h1234);
    check("good_addr1", wr_addr[base+1], 10'h202);
    check("good_data1", wr_data[base+1], 16'h5678);

    cpu_mem_addr = 10'h0AB;
    cpu_mem_wr   = 1'b1;
    cpu_wr_data  = 16'hCAFE;
    #1;
    check("mux_addr", mem_addr, 10'h0AB);
    check("mux_wr", mem_wr, 1);
    check("mux_data", mem_wr_data, 16'hCAFE);
    cpu_mem_wr = 1'b0;
    #1;
    check("mux_wr_low", mem_wr, 0);

    // boot_req with a simultaneous header byte: byte must be dropped
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    tick();
    boot_req = 1'b0;
    rx_valid = 1'b0;
    check("boot_cpu_rst", cpu_rst, 1);
    check("boot_loading", loading, 1);
    check("boot_done", load_done, 0);
    check("boot_err", load_err, 0);
    base = wr_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h47);
    check("boot_frame_done", load_done, 1);
    check("boot_frame_wr_cnt", wr_cnt - base, 1);
    check("boot_frame_data", wr_data[base], 16'h1234);

    // Bad checksum, then a good resend leaves load_err set
    pulse_boot();
    base = wr_cnt;
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h17);
    check("bad_err", load_err, 1);
    check("bad_cpu_rst", cpu_rst, 1);
    check("bad_done", load_done, 0);
    send_byte(8'h55); send_byte(8'h02); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h16);
    check("resend_done", load_done, 1);
    check("resend_err_sticky", load_err, 1);
    check("resend_cpu_rst", cpu_rst, 0);
    check("resend_wr_cnt", wr_cnt - base, 4);

    // LEN=0 means 256 words; sum of 512 x 0xAA is 0 mod 256
    pulse_boot();
    base = wr_cnt;
    send_byte(8'h55); send_byte(8'h00);
    for (int i = 0; i < 512; i++) send_byte(8'hAA);
    send_byte(8'h00);
    check("len0_done", load_done, 1);
    check("len0_wr_cnt", wr_cnt - base, 256);
    check("len0_first_addr", wr_addr[base], 10'h200);
    check("len0_mid_addr", wr_addr[base+100], 10'h2C8);
    check("len0_last_addr", wr_addr[base+255], 10'h3FE);
    check("len0_last_data", wr_data[base+255], 16'hAAAA);

    // Timeout mid-frame
    pulse_boot();
    base = wr_cnt;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h34);
    repeat (90) tick();
    check("tmo_early_err", load_err, 0);
    repeat (15) tick();
    check("tmo_err", load_err, 1);
    check("tmo_cpu_rst", cpu_rst, 1);
    check("tmo_no_wr", wr_cnt - base, 0);
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h47);
    check("tmo_reload_done", load_done, 1);
    check("tmo_reload_wr_cnt", wr_cnt - base, 1);
    check("tmo_reload_addr", wr_addr[base], 10'h200);
    check("tmo_reload_data", wr_data[base], 16'h1234);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
